// File: rtl/beam_power_trigger_if.sv
// beam_power_trigger_if: beam samples, threshold programming, mask and trigger outputs
interface beam_power_trigger_if #(
  parameter int NBEAMS = 48,
  parameter int NSAMP = 8,
  parameter int NBITS = 7,
  parameter int NLEVEL = 2,
  parameter int TBITS = 18
);
  localparam int AW = NBEAMS > 1 ? $clog2(NBEAMS) : 1;
  logic [NBEAMS-1:0][NSAMP*NBITS-1:0] beam;
  logic [TBITS-1:0] thresh;
  logic [AW-1:0] thresh_addr;
  logic [NLEVEL-1:0] thresh_wr;
  logic [NLEVEL-1:0] thresh_update;
  logic [NBEAMS-1:0] mask;
  logic [NLEVEL*NBEAMS-1:0] trigger;
  logic [NLEVEL-1:0] update_ack;
  modport master (
    output beam, thresh, thresh_addr, thresh_wr, thresh_update, mask,
    input trigger, update_ack
  );
  modport slave (
    input beam, thresh, thresh_addr, thresh_wr, thresh_update, mask,
    output trigger, update_ack
  );
endinterface

// File: rtl/beam_power_trigger.sv
// beam_power_trigger: per-beam windowed power compared against shadowed multi-level thresholds with holdoff
module beam_power_trigger #(
  parameter int NBEAMS = 48,
  parameter int NSAMP = 8,
  parameter int NBITS = 7,
  parameter int NLEVEL = 2,
  parameter int TBITS = 18,
  parameter int WINDOW = 2,
  parameter int HOLDOFF = 4
) (
  input logic clk_i,
  input logic rst_i,
  beam_power_trigger_if.slave bus
);
  localparam int SQW = 2 * NBITS;
  localparam int PW = SQW + $clog2(NSAMP);
  localparam int SW = PW + $clog2(WINDOW);
  localparam int CW = SW > TBITS ? SW : TBITS;
  localparam int HW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
  logic [SQW-1:0] sq [NBEAMS][NSAMP];
  logic [PW-1:0] p [NBEAMS];
  logic [PW-1:0] psum [NBEAMS];
  logic [PW-1:0] h [NBEAMS][WINDOW];
  logic [SW-1:0] s [NBEAMS];
  logic [TBITS-1:0] shadow [NLEVEL][NBEAMS];
  logic [TBITS-1:0] active [NLEVEL][NBEAMS];
  logic [HW-1:0] cnt [NLEVEL][NBEAMS];
  logic [HW-1:0] cnt_n [NLEVEL][NBEAMS];
  logic hit [NLEVEL][NBEAMS];
  function automatic logic [SQW-1:0] square(input logic signed [NBITS-1:0] v);
    return SQW'(v) * SQW'(v);
  endfunction
  always_comb begin
    for (int b = 0; b < NBEAMS; b++) begin
      psum[b] = '0;
      for (int j = 0; j < NSAMP; j++) psum[b] = psum[b] + PW'(sq[b][j]);
    end
  end
  always_comb begin
    for (int l = 0; l < NLEVEL; l++) begin
      for (int b = 0; b < NBEAMS; b++) begin
        hit[l][b] = (CW'(s[b]) > CW'(active[l][b])) && cnt[l][b] == '0 && !bus.mask[b];
        cnt_n[l][b] = hit[l][b] ? HW'(HOLDOFF) : (cnt[l][b] != '0 ? cnt[l][b] - HW'(1) : '0);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sq <= '{default: '0};
      p <= '{default: '0};
      h <= '{default: '0};
      s <= '{default: '0};
      cnt <= '{default: '0};
      shadow <= '{default: '1};
      active <= '{default: '1};
      bus.trigger <= '0;
      bus.update_ack <= '0;
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        for (int j = 0; j < NSAMP; j++) sq[b][j] <= square(bus.beam[b][j*NBITS +: NBITS]);
        p[b] <= psum[b];
        h[b][0] <= p[b];
        for (int i = 1; i < WINDOW; i++) h[b][i] <= h[b][i-1];
        s[b] <= s[b] + SW'(p[b]) - SW'(h[b][WINDOW-1]);
      end
      for (int l = 0; l < NLEVEL; l++) begin
        for (int b = 0; b < NBEAMS; b++) begin
          cnt[l][b] <= cnt_n[l][b];
          bus.trigger[l*NBEAMS+b] <= hit[l][b];
        end
        if (bus.thresh_update[l]) active[l] <= shadow[l];
        if (bus.thresh_wr[l] && int'(bus.thresh_addr) < NBEAMS) shadow[l][bus.thresh_addr] <= bus.thresh;
      end
      bus.update_ack <= bus.thresh_update;
    end
  end
endmodule

// File: tb/tb_beam_power_trigger.sv
// tb_beam_power_trigger: randomized and directed stimulus scored against a cycle-indexed power/threshold model
module tb_beam_power_trigger;
  localparam int NBEAMS = 48, NSAMP = 8, NBITS = 7, NLEVEL = 2, TBITS = 18, WINDOW = 2, HOLDOFF = 4;
  localparam int NT = NLEVEL * NBEAMS;
  localparam int AW = $clog2(NBEAMS);
  localparam int MAXC = 4096;
  localparam longint ONES = (64'd1 << TBITS) - 1;
  typedef struct {
    logic [NT-1:0] trig;
    logic [NLEVEL-1:0] ack;
    int t;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  beam_power_trigger_if #(.NBEAMS(NBEAMS), .NSAMP(NSAMP), .NBITS(NBITS), .NLEVEL(NLEVEL), .TBITS(TBITS)) bus();
  beam_power_trigger #(.NBEAMS(NBEAMS), .NSAMP(NSAMP), .NBITS(NBITS), .NLEVEL(NLEVEL), .TBITS(TBITS),
    .WINDOW(WINDOW), .HOLDOFF(HOLDOFF)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  exp_t m;
  int tests = 0, fails = 0, t = 0, last_rst = -1;
  int samp [NBEAMS][NSAMP];
  int pw [MAXC][NBEAMS];
  longint shadow [NLEVEL][NBEAMS];
  longint active [NLEVEL][NBEAMS];
  int next_ok [NLEVEL][NBEAMS];
  logic [NBEAMS-1:0] mask;
  task automatic set_beam(input int b, input int v);
    for (int j = 0; j < NSAMP; j++) samp[b][j] = v;
  endtask
  task automatic fill(input int v);
    for (int b = 0; b < NBEAMS; b++) set_beam(b, v);
  endtask
  task automatic cyc(input logic r, input logic [NLEVEL-1:0] wr = '0, input logic [NLEVEL-1:0] upd = '0,
                     input int addr = 0, input int thr = 0);
    exp_t e;
    int s;
    for (int b = 0; b < NBEAMS; b++) begin
      pw[t][b] = 0;
      for (int j = 0; j < NSAMP; j++) pw[t][b] += samp[b][j] * samp[b][j];
    end
    e.trig = '0;
    e.ack = r ? '0 : upd;
    e.t = t;
    if (!r) begin
      for (int b = 0; b < NBEAMS; b++) begin
        s = 0;
        for (int k = 0; k < WINDOW; k++) begin
          int ed;
          ed = t - 3 - k;
          if (ed >= 0 && ed > last_rst) s += pw[ed][b];
        end
        for (int l = 0; l < NLEVEL; l++) begin
          if (longint'(s) > active[l][b] && !mask[b] && t >= next_ok[l][b]) begin
            e.trig[l*NBEAMS+b] = 1'b1;
            next_ok[l][b] = t + HOLDOFF + 1;
          end
        end
      end
    end
    if (r) begin
      for (int l = 0; l < NLEVEL; l++)
        for (int b = 0; b < NBEAMS; b++) begin
          shadow[l][b] = ONES;
          active[l][b] = ONES;
          next_ok[l][b] = 0;
        end
      last_rst = t;
    end else begin
      for (int l = 0; l < NLEVEL; l++) begin
        if (upd[l]) for (int b = 0; b < NBEAMS; b++) active[l][b] = shadow[l][b];
        if (wr[l] && addr < NBEAMS) shadow[l][addr] = longint'(thr);
      end
    end
    q.push_back(e);
    rst = r;
    bus.thresh_wr = wr;
    bus.thresh_update = upd;
    bus.thresh_addr = AW'(addr);
    bus.thresh = TBITS'(thr);
    bus.mask = mask;
    for (int b = 0; b < NBEAMS; b++)
      for (int j = 0; j < NSAMP; j++) bus.beam[b][j*NBITS +: NBITS] = NBITS'(samp[b][j]);
    t++;
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      m = q.pop_front();
      tests++;
      if (bus.trigger !== m.trig || bus.update_ack !== m.ack) begin
        fails++;
        $display("FAIL cycle %0d outputs: trigger %h ack %b, expected trigger %h ack %b",
                 m.t, bus.trigger, bus.update_ack, m.trig, m.ack);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end
  initial begin
    int amp;
    logic r;
    logic [NLEVEL-1:0] wr, upd;
    mask = '0;
    fill(0);
    cyc(1);
    cyc(1);
    fill(-64);
    repeat (10) begin
      for (int b = 0; b < NBEAMS; b++) mask[b] = ($urandom_range(0, 1) == 0);
      cyc(0);
    end
    mask = '0;
    fill(0);
    repeat (4) cyc(0);
    cyc(0, 2'b01, 2'b00, 3, 1000);
    cyc(0, 2'b00, 2'b01);
    repeat (4) cyc(0);
    set_beam(3, 8);
    cyc(0);
    set_beam(3, 0);
    repeat (6) cyc(0);
    set_beam(3, 8);
    repeat (20) cyc(0);
    mask[3] = 1'b1;
    repeat (8) cyc(0);
    mask[3] = 1'b0;
    repeat (6) cyc(0);
    set_beam(3, 0);
    repeat (5) cyc(0);
    cyc(0, 2'b01, 2'b00, 3, 1024);
    cyc(0, 2'b00, 2'b01);
    set_beam(3, 8);
    repeat (8) cyc(0);
    set_beam(3, 0);
    repeat (5) cyc(0);
    cyc(0, 2'b01, 2'b00, 3, 1023);
    cyc(0, 2'b00, 2'b01);
    set_beam(3, 8);
    repeat (8) cyc(0);
    set_beam(3, 0);
    repeat (5) cyc(0);
    set_beam(5, 6);
    cyc(0, 2'b10, 2'b10, 5, 500);
    repeat (8) cyc(0);
    cyc(0, 2'b00, 2'b10);
    repeat (8) cyc(0);
    set_beam(5, 0);
    cyc(0, 2'b11, 2'b00, 50, 0);
    cyc(0, 2'b11, 2'b00, 63, 0);
    cyc(0, 2'b00, 2'b11);
    fill(30);
    repeat (6) cyc(0);
    fill(0);
    repeat (4) cyc(0);
    repeat (400) begin
      for (int b = 0; b < NBEAMS; b++) begin
        amp = $urandom_range(0, 12);
        for (int j = 0; j < NSAMP; j++)
          samp[b][j] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) - 64
                                                    : int'($urandom_range(0, 2 * amp)) - amp;
        mask[b] = ($urandom_range(0, 3) == 0);
      end
      r = ($urandom_range(0, 99) == 0);
      wr = NLEVEL'($urandom_range(0, 3));
      for (int l = 0; l < NLEVEL; l++) upd[l] = ($urandom_range(0, 7) == 0);
      cyc(r, wr, upd, $urandom_range(0, 63), $urandom_range(0, 1500));
    end
    mask = '0;
    fill(0);
    for (int b = 0; b < NBEAMS; b++) cyc(0, 2'b11, 2'b00, b, 100);
    cyc(0, 2'b00, 2'b11);
    fill(10);
    repeat (12) cyc(0);
    cyc(1);
    repeat (15) cyc(0);
    fill(0);
    repeat (6) cyc(0);
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
